apb_timer_cmp: RTL

APB_TIMER_CMP -- requirements
Module: apb_timer_cmp

---
 rtl/apb_timer_cmp.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/apb_timer_cmp.sv
// APB-mapped 32-bit timer with prescaler, compare register and sticky MATCH flag.
// One wait state per transfer; writes commit at the end of the ACK cycle.
module apb_timer_cmp #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int PRESC_WIDTH    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      irq_o
);

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_e;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_COUNT  = 3'd1;
  localparam logic [2:0] REG_CMP    = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam int         PRESC_LSB  = 8;

  state_e                 state_q;
  logic                   pready_q;
  logic                   pslverr_q;
  logic [31:0]            prdata_q;
  logic                   wrPend_q;
  logic [2:0]             wrAddr_q;
  logic [31:0]            wrData_q;

  logic                   en_q, en_d;
  logic                   autoClr_q, autoClr_d;
  logic                   irqEn_q, irqEn_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] prescCnt_q, prescCnt_d;
  logic [31:0]            count_q, count_d;
  logic [31:0]            cmp_q, cmp_d;
  logic                   match_q, match_d;

  logic [2:0]             regSel;
  logic                   regMapped;
  logic                   accessStart;
  logic [31:0]            readValue;
  logic                   commit;
  logic                   wrCtrl, wrCount, wrCmp, wrStatus;
  logic                   tick;
  logic                   hit;
  logic                   unusedAddrBits;

  assign regSel         = paddr_i[4:2];
  assign regMapped      = (regSel[2] == 1'b0);
  assign accessStart    = (state_q == ST_IDLE) && psel_i && penable_i;
  assign unusedAddrBits = ^{paddr_i[APB_ADDR_WIDTH-1:5], paddr_i[1:0]};

  always_comb begin
    readValue = '0;
    case (regSel)
      REG_CTRL: begin
        readValue[0]                         = en_q;
        readValue[1]                         = autoClr_q;
        readValue[2]                         = irqEn_q;
        readValue[PRESC_LSB +: PRESC_WIDTH]  = presc_q;
      end
      REG_COUNT:  readValue = count_q;
      REG_CMP:    readValue = cmp_q;
      REG_STATUS: readValue[0] = match_q;
      default:    readValue = '0;
    endcase
  end

  // Handshake FSM: read data is captured entering ACK, the write is held until ACK ends.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      wrPend_q  <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accessStart) begin
            state_q   <= ST_ACK;
            pready_q  <= 1'b1;
            prdata_q  <= pwrite_i ? 32'd0 : readValue;
            pslverr_q <= !regMapped;
            wrPend_q  <= pwrite_i && regMapped;
            wrAddr_q  <= regSel;
            wrData_q  <= pwdata_i;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pready_q  <= 1'b0;
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
          wrPend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign commit   = (state_q == ST_ACK) && wrPend_q;
  assign wrCtrl   = commit && (wrAddr_q == REG_CTRL);
  assign wrCount  = commit && (wrAddr_q == REG_COUNT);
  assign wrCmp    = commit && (wrAddr_q == REG_CMP);
  assign wrStatus = commit && (wrAddr_q == REG_STATUS);

  assign tick = en_q && (prescCnt_q == presc_q);
  assign hit  = tick && (count_q == cmp_q);

  // Timer next state: APB writes override tick updates, but a match beats a W1C.
  always_comb begin
    en_d       = en_q;
    autoClr_d  = autoClr_q;
    irqEn_d    = irqEn_q;
    presc_d    = presc_q;
    prescCnt_d = prescCnt_q;
    count_d    = count_q;
    cmp_d      = cmp_q;
    match_d    = match_q;

    if (!en_q || wrCtrl || tick) begin
      prescCnt_d = '0;
    end else begin
      prescCnt_d = prescCnt_q + 1'b1;
    end

    if (tick) begin
      count_d = (hit && autoClr_q) ? 32'd0 : count_q + 32'd1;
    end

    if (wrStatus && wrData_q[0]) begin
      match_d = 1'b0;
    end
    if (hit) begin
      match_d = 1'b1;
    end

    if (wrCtrl) begin
      en_d      = wrData_q[0];
      autoClr_d = wrData_q[1];
      irqEn_d   = wrData_q[2];
      presc_d   = wrData_q[PRESC_LSB +: PRESC_WIDTH];
    end
    if (wrCount) begin
      count_d = wrData_q;
    end
    if (wrCmp) begin
      cmp_d = wrData_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q       <= 1'b0;
      autoClr_q  <= 1'b0;
      irqEn_q    <= 1'b0;
      presc_q    <= '0;
      prescCnt_q <= '0;
      count_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
    end else begin
      en_q       <= en_d;
      autoClr_q  <= autoClr_d;
      irqEn_q    <= irqEn_d;
      presc_q    <= presc_d;
      prescCnt_q <= prescCnt_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign irq_o     = match_q & irqEn_q;

endmodule
